// File: rtl/axil_crossbar_sm_wr.sv
// Write-channel routing FSM of an AXI-Lite crossbar: routes the granted master's
// AW/W/B handshakes to the single slave port and answers with SLVERR if B never comes.
package axil_pkg;
    localparam int NUMBER_MASTER  = 4;
    localparam int AXI_ADDR_WIDTH = 32;
endpackage

module axil_crossbar_sm_wr
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUMBER_MASTER-1:0] grant_wr,
    input  logic [NUMBER_MASTER-1:0] m_axil_awvalid,
    input  logic [NUMBER_MASTER-1:0] m_axil_wvalid,
    input  logic [NUMBER_MASTER-1:0] m_axil_bready,
    input  logic                     s_axil_awready,
    input  logic                     s_axil_wready,
    input  logic [1:0]               s_axil_bresp,
    input  logic                     s_axil_bvalid,
    output logic [NUMBER_MASTER-1:0] m_axil_awready,
    output logic [NUMBER_MASTER-1:0] m_axil_wready,
    output logic [1:0]               m_axil_bresp [NUMBER_MASTER],
    output logic [NUMBER_MASTER-1:0] m_axil_bvalid,
    output logic                     wr_busy,
    output logic                     wr_done,
    output logic                     wr_timeout
);
    localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (NUMBER_MASTER < 1 || AXI_ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axil_crossbar_sm_wr: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, ADDR_DATA, RESP, ERR, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, grant_idx;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aw_hs, w_hs, b_hs;

    // Lowest set grant bit wins when more than one is presented.
    always_comb begin
        grant_idx = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (grant_wr[i]) grant_idx = IDX_W'(i);
        end
    end

    assign aw_hs = m_axil_awvalid[idx_q] && s_axil_awready && !aw_done_q;
    assign w_hs  = m_axil_wvalid[idx_q] && s_axil_wready && !w_done_q;
    assign b_hs  = s_axil_bvalid && m_axil_bready[idx_q];

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        cnt_d          = cnt_q;
        timeout_d      = 1'b0;
        m_axil_awready = '0;
        m_axil_wready  = '0;
        m_axil_bvalid  = '0;
        m_axil_bresp   = '{default: 2'b00};

        case (state_q)
            IDLE: begin
                if (grant_wr != '0) begin
                    idx_d   = grant_idx;
                    state_d = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                m_axil_awready[idx_q] = s_axil_awready && !aw_done_q;
                m_axil_wready[idx_q]  = s_axil_wready && !w_done_q;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                m_axil_bvalid[idx_q] = s_axil_bvalid;
                m_axil_bresp[idx_q]  = s_axil_bresp;
                cnt_d = cnt_q + 1'b1;
                if (b_hs) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end
            end
            ERR: begin
                // The slave has given up on us; answer the master locally.
                m_axil_bvalid[idx_q] = 1'b1;
                m_axil_bresp[idx_q]  = RESP_SLVERR;
                if (m_axil_bready[idx_q]) state_d = DONE;
            end
            DONE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign wr_busy    = (state_q != IDLE);
    assign wr_done    = (state_q == DONE);
    assign wr_timeout = timeout_q;
endmodule

// File: tb/tb_axil_crossbar_sm_wr.sv
// Bench for axil_crossbar_sm_wr: directed and randomized write transactions,
// each cycle compared against expectations derived from the transaction phase.
module tb_axil_crossbar_sm_wr;
    import axil_pkg::*;

    localparam int TO = 8;

    logic                     aclk = 1'b0;
    logic                     areset;
    logic [NUMBER_MASTER-1:0] grant_wr, m_axil_awvalid, m_axil_wvalid, m_axil_bready;
    logic                     s_axil_awready, s_axil_wready, s_axil_bvalid;
    logic [1:0]               s_axil_bresp;
    logic [NUMBER_MASTER-1:0] m_axil_awready, m_axil_wready, m_axil_bvalid;
    logic [1:0]               m_axil_bresp [NUMBER_MASTER];
    logic                     wr_busy, wr_done, wr_timeout;

    logic [3:0] e_awready, e_wready, e_bvalid;
    logic [1:0] e_bresp [4];
    logic       e_busy, e_done, e_timeout;

    int total = 0;
    int bad   = 0;

    axil_crossbar_sm_wr #(.TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset), .grant_wr(grant_wr),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_bready(m_axil_bready), .s_axil_awready(s_axil_awready),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .wr_busy(wr_busy), .wr_done(wr_done),
        .wr_timeout(wr_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        e_awready = '0; e_wready = '0; e_bvalid = '0;
        for (int i = 0; i < 4; i++) e_bresp[i] = 2'b00;
        e_busy = 1'b0; e_done = 1'b0; e_timeout = 1'b0;
    endtask

    task automatic junk();
        m_axil_awvalid = 4'($urandom);
        m_axil_wvalid  = 4'($urandom);
        m_axil_bready  = 4'($urandom);
        s_axil_awready = 1'($urandom);
        s_axil_wready  = 1'($urandom);
        s_axil_bvalid  = 1'($urandom);
        s_axil_bresp   = 2'($urandom);
    endtask

    // Let inputs settle, compare mid-cycle, then move to just after the next edge.
    task automatic cyc(input string ph);
        logic [7:0] gr, er;
        #4;
        for (int i = 0; i < 4; i++) begin
            gr[2*i +: 2] = m_axil_bresp[i];
            er[2*i +: 2] = e_bresp[i];
        end
        chk({ph, ".awready"}, 32'(m_axil_awready), 32'(e_awready));
        chk({ph, ".wready"},  32'(m_axil_wready),  32'(e_wready));
        chk({ph, ".bvalid"},  32'(m_axil_bvalid),  32'(e_bvalid));
        chk({ph, ".bresp"},   32'(gr),             32'(er));
        chk({ph, ".busy"},    32'(wr_busy),        32'(e_busy));
        chk({ph, ".done"},    32'(wr_done),        32'(e_done));
        chk({ph, ".timeout"}, 32'(wr_timeout),     32'(e_timeout));
        @(posedge aclk);
        #1;
    endtask

    task automatic txn(input logic [3:0] g, input logic [3:0] g2, input bit rnd,
                       input int aw_lat, input int w_lat, input int b_lat,
                       input logic [1:0] rsp, input int rdy_lat, input int abort_k);
        int  idx, n, k, j;
        bit  aw_ok, w_ok, aw_hs, w_hs, to_err, fin;
        idx = 0;
        for (int i = 3; i >= 0; i--) if (g[i]) idx = i;

        junk(); grant_wr = g;
        clear_exp();
        cyc("idle_grant");

        grant_wr = g2;
        aw_ok = 1'b0; w_ok = 1'b0; n = 0;
        while (!(aw_ok && w_ok)) begin
            junk();
            s_axil_awready = (rnd && n < 20) ? 1'($urandom) : 1'b1;
            s_axil_wready  = (rnd && n < 20) ? 1'($urandom) : 1'b1;
            m_axil_awvalid[idx] = aw_ok ? 1'($urandom) : (n >= aw_lat);
            m_axil_wvalid[idx]  = w_ok  ? 1'($urandom) : (n >= w_lat);
            clear_exp(); e_busy = 1'b1;
            e_awready[idx] = !aw_ok && s_axil_awready;
            e_wready[idx]  = !w_ok && s_axil_wready;
            aw_hs = !aw_ok && m_axil_awvalid[idx] && s_axil_awready;
            w_hs  = !w_ok && m_axil_wvalid[idx] && s_axil_wready;
            cyc("addr");
            aw_ok = aw_ok || aw_hs;
            w_ok  = w_ok || w_hs;
            n++;
        end

        k = 0; fin = 1'b0; to_err = 1'b0;
        while (!fin) begin
            junk();
            s_axil_bvalid = (b_lat >= 0 && k >= b_lat);
            if (s_axil_bvalid) s_axil_bresp = rsp;
            m_axil_bready[idx] = (k >= rdy_lat);
            if (abort_k == k) begin
                areset = 1'b1; s_axil_bvalid = 1'b1; m_axil_bready[idx] = 1'b0;
            end
            clear_exp(); e_busy = 1'b1;
            e_bvalid[idx] = s_axil_bvalid;
            e_bresp[idx]  = s_axil_bresp;
            cyc("resp");
            if (abort_k == k) begin
                areset = 1'b0; grant_wr = '0; junk(); s_axil_bvalid = 1'b1;
                clear_exp();
                cyc("post_rst");
                cyc("post_rst2");
                return;
            end
            if (s_axil_bvalid && m_axil_bready[idx]) fin = 1'b1;
            else if (k == TO - 1) begin fin = 1'b1; to_err = 1'b1; end
            k++;
        end

        if (to_err) begin
            j = 0; fin = 1'b0;
            while (!fin) begin
                junk();
                m_axil_bready[idx] = (j >= rdy_lat);
                clear_exp(); e_busy = 1'b1; e_bvalid[idx] = 1'b1; e_bresp[idx] = 2'b10;
                e_timeout = (j == 0);
                cyc("err");
                fin = m_axil_bready[idx];
                j++;
            end
        end

        junk(); grant_wr = g2;
        clear_exp(); e_busy = 1'b1; e_done = 1'b1;
        cyc("done");
        junk(); grant_wr = '0;
        clear_exp();
        cyc("idle_after");
    endtask

    initial begin
        logic [3:0] g, g2;
        int bl, ab;
        areset = 1'b1; grant_wr = '0; junk();
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0; junk(); s_axil_bvalid = 1'b1; s_axil_awready = 1'b1; s_axil_wready = 1'b1;
        clear_exp();
        cyc("reset");

        txn(4'b0100, 4'b0100, 1'b0, 0, 0, 0, 2'b00, 0, -1);        // simultaneous AW/W
        txn(4'b0001, 4'b0001, 1'b0, 3, 0, 1, 2'b01, 2, -1);        // W three cycles before AW
        txn(4'b1000, 4'b1000, 1'b0, 1, 1, -1, 2'b00, 2, -1);       // slave silent: timeout
        txn(4'b0110, 4'b1000, 1'b0, 1, 2, 0, 2'b11, 0, -1);        // grant change ignored
        txn(4'b0010, 4'b0010, 1'b0, 0, 0, 0, 2'b00, 99, 2);        // reset during RESP
        txn(4'b1000, 4'b1000, 1'b0, 0, 0, TO - 1, 2'b01, 0, -1);   // B on the timeout cycle

        for (int t = 0; t < 40; t++) begin
            g  = 4'($urandom_range(1, 15));
            g2 = 4'($urandom);
            bl = int'($urandom_range(0, 10)) - 1;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            txn(g, g2, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bl,
                2'($urandom), int'($urandom_range(0, 4)), ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axil_crossbar_sm_wr.md
AXIL_CROSSBAR_SM_WR -- requirements
Module: axil_crossbar_sm_wr

Interface
REQ-001 The block SHALL import axil_pkg and use NUMBER_MASTER and AXI_ADDR_WIDTH from it.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the maximum cycles spent in RESP before a locally generated error response.
REQ-003 The block SHALL use one clock, aclk, and a synchronous active-high reset, areset.
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
- aclk  in  1  clock, all state updates on rising edge.
- areset  in  1  synchronous, active-high reset.
- grant_wr  in  NUMBER_MASTER  arbiter grant, one-hot, held until wr_done.
- m_axil_awvalid  in  NUMBER_MASTER  per-master AW valid.
- m_axil_wvalid  in  NUMBER_MASTER  per-master W valid.
- m_axil_bready  in  NUMBER_MASTER  per-master B ready.
- s_axil_awready  in  1  slave AW ready.
- s_axil_wready  in  1  slave W ready.
- s_axil_bresp  in  2  slave write response.
- s_axil_bvalid  in  1  slave B valid.
- m_axil_awready  out  NUMBER_MASTER  routed AW ready.
- m_axil_wready  out  NUMBER_MASTER  routed W ready.
- m_axil_bresp  out  2 x [NUMBER_MASTER] unpacked  routed write response.
- m_axil_bvalid  out  NUMBER_MASTER  routed B valid.
- wr_busy  out  1  transaction in progress, state != IDLE.
- wr_done  out  1  one-cycle pulse, transaction complete, arbiter may release grant.
- wr_timeout  out  1  one-cycle pulse on entry to ERR.

Function
REQ-005 FSM states SHALL be IDLE, ADDR_DATA, RESP, ERR, DONE.
REQ-006 IDLE: when grant_wr != 0, the block SHALL latch idx = lowest set bit of grant_wr and go to ADDR_DATA next cycle. All m_axil_* outputs are 0 in IDLE, whatever the slave inputs.
REQ-007 ADDR_DATA: m_axil_awready[idx] SHALL equal s_axil_awready while aw_done=0 and SHALL be 0 once aw_done=1. m_axil_wready[idx] SHALL follow the same rule with wready and w_done. All other master bits SHALL be 0.
REQ-008 aw_done SHALL set on the cycle m_axil_awvalid[idx] && s_axil_awready. w_done SHALL set on m_axil_wvalid[idx] && s_axil_wready. The two are independent and either order is allowed.
REQ-009 When both handshakes are complete the FSM SHALL go to RESP on the next cycle. This includes both completing in the same cycle, or one completing while the other is already set.
REQ-010 RESP: m_axil_bvalid[idx] SHALL equal s_axil_bvalid and m_axil_bresp[idx] SHALL equal s_axil_bresp, combinationally. On s_axil_bvalid && m_axil_bready[idx] the FSM SHALL go to DONE.
REQ-011 A timeout counter, width $clog2(TIMEOUT_CYCLES)+1, SHALL clear on entry to RESP and increment each RESP cycle. If it reaches TIMEOUT_CYCLES-1 with no B handshake, the FSM SHALL go to ERR. A B handshake in that same cycle takes priority and the FSM goes to DONE.
REQ-012 ERR: m_axil_bvalid[idx]=1 and m_axil_bresp[idx]=2'b10 (SLVERR), slave B inputs ignored. wr_timeout SHALL pulse on the first ERR cycle. On m_axil_bready[idx] the FSM SHALL go to DONE.
REQ-013 DONE: wr_done=1 for exactly one cycle, all m_axil_* outputs 0. The FSM SHALL then return to IDLE, clearing aw_done, w_done and the counter.
REQ-014 grant_wr changes outside IDLE SHALL be ignored. idx stays latched until IDLE.
REQ-015 Non-granted masters SHALL never see a ready or bvalid asserted.

Reset
REQ-016 With areset=1 at a clock edge, the block SHALL set state=IDLE, idx=0, aw_done=w_done=0 and counter=0. All outputs SHALL be 0 from the following cycle.
REQ-017 Reset asserted mid-transaction, in any state, SHALL abort it with no wr_done or wr_timeout pulse.

Verification (NUMBER_MASTER=4, TIMEOUT_CYCLES=8)
REQ-018 grant_wr=4'b0100, AW and W handshakes in the same cycle, slave bresp=2'b00 with bready -> m_axil_bvalid=4'b0100, bresp[2]=00, wr_done pulse; other masters see all zeros.
REQ-019 grant_wr=4'b0001, W accepted 3 cycles before AW -> m_axil_wready[0] is 0 after the W handshake, RESP entered the cycle after AW, wr_done one cycle after B.
REQ-020 grant_wr=4'b1000, slave never asserts bvalid -> wr_timeout 8 cycles after RESP entry, m_axil_bresp[3]=2'b10, wr_done after m_axil_bready[3].
REQ-021 grant_wr=4'b0110 -> idx=1; grant changed to 4'b1000 during ADDR_DATA -> routing stays on master 1.
REQ-022 areset pulsed during RESP with s_axil_bvalid=1 -> all outputs 0, wr_done never pulses, IDLE after reset.
REQ-023 B handshake on the 8th RESP cycle, the timeout cycle -> DONE, no wr_timeout pulse.
